// File: rtl/uart_tx_arbiter_if.sv
// Bundle between two byte requesters, the TX FIFO write port and the arbiter.
// Handshake: requester k raises reqk with datak/lastk and holds all three stable
// until ackk. ackk is a same-cycle acceptance. wr qualifies w_data and is never
// high while tx_full is high.
interface uart_tx_arbiter_if #(
   parameter int DBIT = 8
) ();
   logic            req0;
   logic [DBIT-1:0] data0;
   logic            last0;
   logic            ack0;
   logic            req1;
   logic [DBIT-1:0] data1;
   logic            last1;
   logic            ack1;
   logic            tx_full;
   logic [DBIT-1:0] w_data;
   logic            wr;
   logic [1:0]      grant;

   modport master (
      output req0, data0, last0, req1, data1, last1, tx_full,
      input  ack0, ack1, w_data, wr, grant
   );

   modport slave (
      input  req0, data0, last0, req1, data1, last1, tx_full,
      output ack0, ack1, w_data, wr, grant
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter that shares one TX FIFO write port between
// two byte requesters, with burst-limit and stall-timeout forced release.
module uart_tx_arbiter #(
   parameter int DBIT      = 8,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_arbiter_if.slave   bus,
   output logic [1:0]         dbg_state
);

   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          state;
   logic            rr_ptr;
   logic [BW-1:0]   burst_cnt;
   logic [IW-1:0]   idle_cnt;

   logic            granted;
   logic            own_req;
   logic            own_last;
   logic [DBIT-1:0] own_data;
   logic            xfer;
   logic            release_now;

   // Owner-side view of the request: everything below is written in terms of k.
   always_comb begin
      own_req  = 1'b0;
      own_last = 1'b0;
      own_data = '0;
      unique case (state)
         GNT0: begin
            own_req  = bus.req0;
            own_last = bus.last0;
            own_data = bus.data0;
         end
         GNT1: begin
            own_req  = bus.req1;
            own_last = bus.last1;
            own_data = bus.data1;
         end
         default: ;
      endcase
   end

   assign granted = (state != IDLE);
   assign xfer    = granted & own_req & ~bus.tx_full;

   // Last byte and burst limit on the same transfer are one release event.
   assign release_now = granted &
                        ((xfer & (own_last | (burst_cnt == BURST_LAST))) |
                         (~own_req & (idle_cnt == IDLE_LAST)));

   assign bus.wr     = xfer;
   assign bus.w_data = own_data;
   assign bus.ack0   = xfer & (state == GNT0);
   assign bus.ack1   = xfer & (state == GNT1);
   assign bus.grant  = {state == GNT1, state == GNT0};
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         burst_cnt <= '0;
         idle_cnt  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               burst_cnt <= '0;
               idle_cnt  <= '0;
               if (bus.req0 && bus.req1)
                  state <= rr_ptr ? GNT1 : GNT0;
               else if (bus.req0)
                  state <= GNT0;
               else if (bus.req1)
                  state <= GNT1;
            end
            GNT0, GNT1: begin
               if (release_now) begin
                  // Always drop through IDLE so the other port gets a fair tie.
                  state     <= IDLE;
                  rr_ptr    <= (state == GNT0);
                  burst_cnt <= '0;
                  idle_cnt  <= '0;
               end else begin
                  if (xfer)
                     burst_cnt <= burst_cnt + 1'b1;
                  if (own_req)
                     idle_cnt <= '0;
                  else
                     idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
